ingress_frame_fifo: RTL and testbench

Store-and-forward ingress buffer between the external receive MAC byte stream and the dataplane `rx_*` port. It accepts frames byte by byte and writes them into a circular buffer. A frame becomes visible to the dataplane only after its last byte arrives clean and its length is within bounds. Runt, oversize, errored and overflowing frames are rolled back and never reach the parser.

---
 rtl/ingress_frame_fifo.sv | 181 ++++++++++++++++++
 tb/tb_ingress_frame_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_frame_fifo.sv
// Store-and-forward ingress buffer: a frame becomes readable only after it completes clean and in bounds.
// Define INGRESS_FIFO_STATS_EN to build the frame_cnt/drop_cnt statistics counters (tied to zero otherwise).
module ingress_frame_fifo #(
    parameter int DEPTH   = 2048,
    parameter int MIN_LEN = 14,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_error,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);
    // state    | meaning
    // ACCEPT   | storing bytes of the current frame at wr_ptr
    // DISCARD  | current frame already dropped; skip bytes until in_last

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(MAX_LEN + 2);

    typedef logic [AW:0]   ptr_t;
    typedef logic [LW-1:0] len_t;
    typedef enum logic {S_ACCEPT = 1'b0, S_DISCARD = 1'b1} state_t;

    localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);
    localparam len_t LEN_MIN   = len_t'(MIN_LEN);
    localparam len_t LEN_MAX   = len_t'(MAX_LEN);

    state_t     state_q;
    ptr_t       wr_ptr_q, commit_ptr_q;
    ptr_t       rd_ptr_q, rd_ptr_d;
    ptr_t       fetch_ptr_q, fetch_ptr_d;
    len_t       len_q, len_inc;
    logic       in_ready_q;
    logic       beat, full, drop_now, frame_ok, wr_en;

    logic [8:0] mem_q [DEPTH];
    logic [8:0] rd_word;
    logic [8:0] out_word_q, out_word_d;
    logic [8:0] skid_word_q, skid_word_d;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       consume, fetch;

    assign beat     = in_valid && in_ready_q;
    // Occupancy uses the speculative write pointer, so an uncommitted frame still takes space.
    assign full     = ((wr_ptr_q - rd_ptr_q) == PTR_DEPTH);
    assign drop_now = full || (len_q == LEN_MAX);
    assign len_inc  = len_q + len_t'(1);
    assign frame_ok = !in_error && (len_inc >= LEN_MIN) && (len_inc <= LEN_MAX);
    assign wr_en    = beat && (state_q == S_ACCEPT) && !drop_now;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            len_q        <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            in_ready_q <= 1'b1;
            if (beat) begin
                case (state_q)
                    S_ACCEPT: begin
                        if (drop_now) begin
                            wr_ptr_q <= commit_ptr_q;
                            if (in_last) len_q <= '0;
                            else         state_q <= S_DISCARD;
                        end else if (in_last) begin
                            len_q <= '0;
                            if (frame_ok) begin
                                wr_ptr_q     <= wr_ptr_q + ptr_t'(1);
                                commit_ptr_q <= wr_ptr_q + ptr_t'(1);
                            end else begin
                                wr_ptr_q <= commit_ptr_q;
                            end
                        end else begin
                            wr_ptr_q <= wr_ptr_q + ptr_t'(1);
                            len_q    <= len_inc;
                        end
                    end
                    S_DISCARD: begin
                        if (in_last) begin
                            len_q   <= '0;
                            state_q <= S_ACCEPT;
                        end
                    end
                    default: state_q <= S_ACCEPT;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
    end

    // Fetch depends only on registered state; out_ready only steers where the word lands.
    always_comb begin
        consume      = out_valid_q && out_ready;
        fetch        = (fetch_ptr_q != commit_ptr_q) && !skid_valid_q;
        rd_word      = mem_q[fetch_ptr_q[AW-1:0]];
        out_valid_d  = out_valid_q;
        out_word_d   = out_word_q;
        skid_valid_d = skid_valid_q;
        skid_word_d  = skid_word_q;
        rd_ptr_d     = consume ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        fetch_ptr_d  = fetch ? fetch_ptr_q + ptr_t'(1) : fetch_ptr_q;
        if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_word_d   = skid_word_q;
                skid_valid_d = 1'b0;
            end else if (fetch) begin
                out_valid_d = 1'b1;
                out_word_d  = rd_word;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (fetch) begin
            skid_valid_d = 1'b1;
            skid_word_d  = rd_word;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_word_q  <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            skid_valid_q <= skid_valid_d;
            skid_word_q  <= skid_word_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_word_q[7:0];
    assign out_last  = out_word_q[8];

`ifdef INGRESS_FIFO_STATS_EN
    logic        commit_ev, drop_ev;
    logic [15:0] frame_cnt_q, drop_cnt_q;

    assign commit_ev = beat && (state_q == S_ACCEPT) && !drop_now && in_last && frame_ok;
    assign drop_ev   = beat && (state_q == S_ACCEPT) && (drop_now || (in_last && !frame_ok));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (commit_ev && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
            if (drop_ev && (drop_cnt_q != 16'hFFFF))    drop_cnt_q  <= drop_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`else
    assign frame_cnt = 16'h0000;
    assign drop_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_ingress_frame_fifo.sv
// Directed-plus-random bench for ingress_frame_fifo against a frame-level reference model.
module tb_ingress_frame_fifo;
    localparam int DEPTH   = 2048;
    localparam int MIN_LEN = 14;
    localparam int MAX_LEN = 1518;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        in_error = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready = 1'b0;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    ingress_frame_fifo #(.DEPTH(DEPTH), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_error(in_error),
        .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    int         held = 0;          // committed bytes not yet transferred out
    int         exp_frames = 0;
    int         exp_drops = 0;
    bit         rand_ready = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] rx_q[$];
    logic       stalled = 1'b0;
    logic [8:0] prev_word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef INGRESS_FIFO_STATS_EN
        return (n > 65535) ? 32'h0000_FFFF : 32'(n);
`else
        return (n < 0) ? 32'hFFFF_FFFF : 32'h0;
`endif
    endfunction

    // Output monitor: records transfers and checks hold-while-stalled.
    always @(negedge clk) begin
        if (!resetn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_word", 32'({out_last, out_data}), 32'(prev_word));
            end
            stalled   = out_valid && !out_ready;
            prev_word = {out_last, out_data};
            if (out_valid && out_ready) begin
                rx_q.push_back({out_last, out_data});
                held--;
            end
        end
    end

    task automatic send_beat(input logic [7:0] d, input logic last, input logic err);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_error = err;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_error = 1'b0;
    endtask

    // Frame fate from the buffer rules: clean, within bounds, and fits in the free space.
    task automatic send_frame(input int len, input bit err);
        bit         commit;
        logic [7:0] b;
        commit = !err && (len >= MIN_LEN) && (len <= MAX_LEN) && (len <= DEPTH - held);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            if (commit) exp_q.push_back({(i == len - 1), b});
            send_beat(b, (i == len - 1), err && (i == len - 1));
        end
        if (commit) begin
            held += len;
            exp_frames++;
        end else begin
            exp_drops++;
        end
    endtask

    task automatic drain_compare(input string tag, input int budget);
        int n;
        n = 0;
        while ((rx_q.size() < exp_q.size()) && (n < budget)) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; (i < exp_q.size()) && (i < rx_q.size()); i++)
            check(tag, 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), cnt_exp(exp_frames));
        check({tag, "_drop_cnt"}, 32'(drop_cnt), cnt_exp(exp_drops));
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check_counters("rst");
        @(posedge clk); #1;
        resetn = 1'b1;
        check("in_ready_pre", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("in_ready_up", 32'(in_ready), 32'd1);

        // 64-byte clean frame with latency check
        out_ready = 1'b1;
        send_frame(64, 1'b0);
        check("lat_idle", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid", 32'(out_valid), 32'd1);
        check("lat_first", 32'({out_last, out_data}), 32'(exp_q[0]));
        drain_compare("f64", 400);
        check_counters("f64");

        // Errored frame then clean frame
        send_frame(64, 1'b1);
        send_frame(60, 1'b0);
        drain_compare("err", 400);
        check_counters("err");

        // Runt and giant, each followed by a minimum frame
        send_frame(10, 1'b0);
        send_frame(14, 1'b0);
        send_frame(1519, 1'b0);
        send_frame(14, 1'b0);
        drain_compare("bounds", 400);
        check_counters("bounds");

        // Overflow with output stalled
        out_ready = 1'b0;
        for (int f = 0; f < 4; f++) send_frame(600, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("ovf_held_valid", 32'(out_valid), 32'd1);
        check("ovf_held_first", 32'({out_last, out_data}), 32'(exp_q[0]));
        check("ovf_exp_bytes", 32'(exp_q.size()), 32'd1800);
        check_counters("ovf");
        out_ready = 1'b1;
        drain_compare("ovf", 4000);

        // Back-to-back minimum frames with random out_ready
        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) send_frame(14, 1'b0);
        rand_ready = 1'b0;
        out_ready = 1'b1;
        drain_compare("rand", 1000);
        check_counters("rand");

        // Full throughput after a stall
        out_ready = 1'b0;
        for (int f = 0; f < 5; f++) send_frame(14, 1'b0);
        repeat (2) @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            check("tput_valid", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        check("tput_empty", 32'(out_valid), 32'd0);
        drain_compare("tput", 200);

        // Reset during output of a committed frame
        send_frame(64, 1'b0);
        for (int i = 0; (i < 200) && (rx_q.size() < 10); i++) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        rx_q.delete();
        exp_q.delete();
        held = 0;
        exp_frames = 0;
        exp_drops = 0;
        check_counters("mid_rst");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        send_frame(20, 1'b0);
        drain_compare("post_rst", 200);
        check_counters("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
